// File: rtl/step_counter_pkg.sv
// Shared types and defaults for the multiplier step counter and its controller.
package step_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter with advance-enable, busy/last status and terminal flag K.
// Define STEP_COUNTER_AUTORELOAD_EN to restart each run automatically from the last loaded Steps.
module step_counter
   import step_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_steps,
   output logic [WIDTH-1:0] o_count,
   output logic             o_busy,
   output logic             o_last,
   output logic             o_k
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_busy;
   logic             r_k;
`ifdef STEP_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] r_reload;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_k     <= 1'b0;
`ifdef STEP_COUNTER_AUTORELOAD_EN
         r_reload <= '0;
`endif
      end else if (i_load) begin
         // Load overrides En and any terminal step in progress
         r_count <= i_steps;
`ifdef STEP_COUNTER_AUTORELOAD_EN
         r_reload <= i_steps;
`endif
         if (i_steps == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_k     <= 1'b1;
         end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_k     <= 1'b0;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_en) begin
                  if (r_count == ONE) begin
                     r_count <= '0;
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_k     <= 1'b1;
                  end else begin
                     r_count <= r_count - ONE;
                  end
               end
            end
            ST_DONE: begin
`ifdef STEP_COUNTER_AUTORELOAD_EN
               // A zero reload value leaves DONE sticky
               if (r_reload != '0) begin
                  r_count <= r_reload;
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
                  r_k     <= 1'b0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_busy  = r_busy;
   assign o_k     = r_k;
   assign o_last  = (r_state == ST_RUN) && (r_count == ONE);

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter: directed scenarios plus random Load/En/Steps
// against a behavioural model; honours STEP_COUNTER_AUTORELOAD_EN when defined.
module tb_step_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic         en = 1'b1;
   logic [W-1:0] steps = '0;
   logic [W-1:0] count;
   logic         busy, last, k;

   int n_checks = 0;
   int n_errors = 0;

   step_counter #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_load  (load),
      .i_en    (en),
      .i_steps (steps),
      .o_count (count),
      .o_busy  (busy),
      .o_last  (last),
      .o_k     (k)
   );

   always #10 clk = ~clk;

   // Behavioural model: remaining steps plus "running"/"finished" flags
   int m_left   = 0;
   bit m_run    = 0;
   bit m_fin    = 0;
   int m_reload = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_run = 0; m_fin = 0; m_reload = 0;
      end else if (load) begin
         m_left   = int'(steps);
         m_reload = int'(steps);
         m_run    = (m_left != 0);
         m_fin    = (m_left == 0);
      end else if (m_run && en) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_run = 0;
            m_fin = 1;
         end
      end
`ifdef STEP_COUNTER_AUTORELOAD_EN
      else if (m_fin && m_reload != 0) begin
         m_left = m_reload;
         m_run  = 1;
         m_fin  = 0;
      end
`endif
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model on every falling edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("model.count", int'(count), m_left);
         chk("model.busy",  int'(busy),  int'(m_run));
         chk("model.k",     int'(k),     int'(m_fin));
         chk("model.last",  int'(last),  int'(m_run && m_left == 1));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   int n;
   int last_n;

   initial begin
      #20 rst = 1'b0;
      repeat (3) step();
      chk("idle.count", int'(count), 0);
      chk("idle.busy",  int'(busy),  0);
      chk("idle.k",     int'(k),     0);

      // Steps=15, Load held two cycles
      load = 1'b1; steps = 4'd15; en = 1'b1;
      step(); chk("hold.count1", int'(count), 15);
      step(); chk("hold.count2", int'(count), 15);
      load = 1'b0;
      n = 0; last_n = -1;
      while (!k && n < 100) begin
         step(); n++;
         if (last && !k) last_n = n;
      end
      chk("max.k_edges", n, 15);
      chk("max.last_at", last_n, 14);
`ifndef STEP_COUNTER_AUTORELOAD_EN
      repeat (40) step();
      chk("sticky.k", int'(k), 1);
      chk("sticky.count", int'(count), 0);
`endif

      // Steps=5 with En toggling, starting low after the load edge
      load = 1'b1; steps = 4'd5; en = 1'b1;
      step();
      load = 1'b0;
      n = 0;
      while (!k && n < 100) begin
         en = (n % 2 == 1);
         step(); n++;
      end
      chk("toggle.k_edges", n, 10);
      en = 1'b1;

      // Steps=0
      load = 1'b1; steps = 4'd0;
      step();
      load = 1'b0;
      chk("zero.k", int'(k), 1);
      chk("zero.busy", int'(busy), 0);
      chk("zero.count", int'(count), 0);

      // Load collides with the terminal step
      load = 1'b1; steps = 4'd2;
      step();
      load = 1'b0;
      step();
      chk("collide.pre_count", int'(count), 1);
      load = 1'b1; steps = 4'd3;
      step();
      load = 1'b0;
      chk("collide.count", int'(count), 3);
      chk("collide.busy", int'(busy), 1);
      chk("collide.k", int'(k), 0);

      // Asynchronous reset mid-run at Count=5
      load = 1'b1; steps = 4'd9;
      step();
      load = 1'b0;
      repeat (4) step();
      chk("areset.pre_count", int'(count), 5);
      #3 rst = 1'b1;
      #1;
      chk("areset.count", int'(count), 0);
      chk("areset.busy", int'(busy), 0);
      chk("areset.last", int'(last), 0);
      chk("areset.k", int'(k), 0);
      step();
      rst = 1'b0;
      step();

`ifdef STEP_COUNTER_AUTORELOAD_EN
      load = 1'b1; steps = 4'd3;
      step();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("auto.count", int'(count), 3 - (i % 4));
         chk("auto.k", int'(k), int'(i % 4 == 3));
         step();
      end
`endif

      // Random Load/En/Steps against the model
      for (int i = 0; i < 400; i++) begin
         load  = ($urandom_range(0, 9) == 0);
         en    = ($urandom_range(0, 9) < 7);
         steps = W'($urandom_range(0, (1 << W) - 1));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/step_counter.md
# step_counter

- Parametrised step counter for the sequential multiplier control path.
- Loads a programmable step count, counts down on enabled cycles, and raises terminal flag K when the count is exhausted.
- Generalises the fixed 4-bit counter in two ways:
  - arbitrary width and per-run step count;
  - advance-enable for stalls, busy/last-step status, and optional auto-reload.
- Sits beside the multiplier datapath: the controller pulses Load to start a multiply and watches K to finish it.

## Interface
Parameters:
- WIDTH, 4, bit width of Steps and Count; legal range 2..16.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Load  in  1  start/restart; loads Steps, and has priority over En.
- En  in  1  advance; Count decrements only on cycles with En=1 in RUN.
- Steps  in  WIDTH  number of steps for the next run; sampled only on Load cycles.
- Count  out  WIDTH  remaining steps (registered).
- Busy  out  1  high while in RUN (registered).
- Last  out  1  high when in RUN with Count==1; combinational from registers.
- K  out  1  terminal flag, high in DONE (registered).

## Operation
States:
- IDLE: Count=0, Busy=0, K=0.
- RUN: Busy=1, K=0.
- DONE: K=1, Busy=0.

Transitions and rules:
- **Reset** (async, at any time, including mid-run): go to IDLE; Count=0, Busy=0, K=0, Last=0.
- **Load=1, any state:**
  - Count<=Steps.
  - If Steps!=0, next state is RUN.
  - If Steps==0, next state is DONE with Count=0.
  - En is ignored that cycle.
- **Held Load:** Load held high for several cycles reloads every cycle. Counting begins on the first edge with Load=0.
- **RUN, Load=0:**
  - En=1 and Count>1: Count<=Count-1.
  - En=1 and Count==1: Count<=0, next state DONE.
  - En=0: hold everything.
- **DONE, Load=0:** sticky. K stays 1 and Count stays 0 until Load or Reset.
- **IDLE, Load=0:** stay in IDLE; En has no effect.
- **Arithmetic:**
  - Count is unsigned WIDTH bits and never wraps below 0.
  - Steps = 2^WIDTH-1 is legal and gives the maximum run length.
- **Simultaneous Load and terminal step:** Load wins. The run restarts, and K does not assert for the abandoned run.

## Timing
- Reset value of every output: Count=0, Busy=0, Last=0, K=0.
- Load sampled at edge n, then after edge n:
  - Busy=1 and Count=Steps;
  - if Steps==0, instead K=1 and Busy=0.
- With En held 1, K rises after edge n+Steps; the RUN dwell is exactly Steps cycles.
- Each En=0 cycle during RUN extends the run by one cycle.
- Last is high during the final RUN cycle, so the controller can prepare the final datapath step.
- K deasserts on the edge that samples Load.

## Configuration
Macro: STEP_COUNTER_AUTORELOAD_EN.

Without the macro:
- DONE is sticky, as described in Operation.

With the macro defined:
- A WIDTH-bit reload register captures Steps on every Load.
- On the terminal step, K is a one-cycle pulse in DONE, and Count reloads from the reload register.
  - The block returns to RUN on the next edge, giving a free-running period of reload+1 cycles with En=1.
- A reload value of 0 holds DONE with K=1, i.e. non-pulsing.
- Load and Reset behave as without the macro.

## Structure
- Package step_counter_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the default WIDTH constant, shared with the multiplier controller.
- No sub-module: state register, count register and output decode live in one module.

## Test plan
Clock period is 20 ns; En=1 unless stated.
- Reset=1 for 20 ns, then released, no Load: Count=0, Busy=0, K=0 throughout; asserting Reset mid-run at Count=5 returns all outputs to 0 asynchronously.
- WIDTH=4, Steps=15, Load held 2 cycles then low:
  - Count reloads 15 both cycles;
  - K rises exactly 15 edges after the last Load edge;
  - Last is high for the one cycle before K rises;
  - K stays high for 40 cycles with no Load.
- Steps=5, En toggled 1/0 every cycle: K rises after 10 edges, and Count holds on every En=0 cycle.
- Steps=0 with Load: K=1 and Busy=0 the next cycle, Count=0.
- Load asserted on the same edge that would take Count 1->0 (Steps=3 reloaded): no K pulse, Count=3, Busy=1.
- STEP_COUNTER_AUTORELOAD_EN defined, Steps=3:
  - K pulses one cycle every 4 cycles;
  - Count sequence is 3,2,1,0,3,2,1,0,...
